// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues in-order word fetches, tags responses with their
// addresses and buffers them for decode; redirects flush the buffer and drop stale responses.
module fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    input  logic        stall_in,
    output logic        out_valid,
    output logic [31:0] out_instr_addr,
    output logic [31:0] out_instr_dat
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
        if (p == TW'(MAX_OUTSTANDING - 1)) begin
            return '0;
        end else begin
            return p + TW'(1);
        end
    endfunction

    logic [31:0]   pc_q, pc_d;
    logic          credit_q, credit_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [OW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [TW-1:0] tag_wr_q, tag_wr_d;
    logic [TW-1:0] tag_rd_q, tag_rd_d;
    logic          out_valid_q, out_valid_d;
    logic [31:0]   out_addr_q, out_addr_d;
    logic [31:0]   out_dat_q, out_dat_d;

    logic [31:0]   fifo_addr_q [FIFO_DEPTH];
    logic [31:0]   fifo_dat_q  [FIFO_DEPTH];
    logic [31:0]   tag_q       [MAX_OUTSTANDING];

    logic          accept_s;
    logic          rsp_s;
    logic          drop_s;
    logic          push_s;
    logic          pop_s;
    logic          fifo_full_s;
    logic [CW-1:0] remain_s;
    logic          unused_redirect_lsb_s;

    // Credit is precomputed from next-state counts, so it only ever reflects registered occupancy.
    assign imem_req_valid = credit_q && !redirect_valid;
    assign imem_req_addr  = pc_q;
    assign out_valid      = out_valid_q;
    assign out_instr_addr = out_addr_q;
    assign out_instr_dat  = out_dat_q;

    assign accept_s    = imem_req_valid && imem_req_ready;
    assign rsp_s       = imem_rsp_valid && (outstanding_q != '0);
    assign drop_s      = rsp_s && (drop_cnt_q != '0);
    assign push_s      = rsp_s && !drop_s && !redirect_valid;
    assign pop_s       = out_valid_q && !stall_in && !redirect_valid;
    assign fifo_full_s = (32'(fifo_cnt_q) == 32'(FIFO_DEPTH));
    assign remain_s    = fifo_cnt_q - CW'(pop_s);

    assign unused_redirect_lsb_s = ^redirect_addr[1:0];

    // Next-state for PC, request credit, in-flight/drop counters and tag-queue pointers.
    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        tag_wr_d      = tag_wr_q;
        tag_rd_d      = tag_rd_q;

        if (redirect_valid) begin
            pc_d = {redirect_addr[31:2], 2'b00};
        end else if (accept_s) begin
            pc_d = pc_q + 32'd4;
        end else begin
            pc_d = pc_q;
        end

        case ({accept_s, rsp_s})
            2'b10:   outstanding_d = outstanding_q + OW'(1);
            2'b01:   outstanding_d = outstanding_q - OW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        // Everything still in flight after a redirect belongs to the old path.
        if (redirect_valid) begin
            drop_cnt_d = outstanding_d;
        end else if (drop_s) begin
            drop_cnt_d = drop_cnt_q - OW'(1);
        end else begin
            drop_cnt_d = drop_cnt_q;
        end

        tag_wr_d = accept_s ? tag_inc(tag_wr_q) : tag_wr_q;
        tag_rd_d = rsp_s ? tag_inc(tag_rd_q) : tag_rd_q;
    end

    // Next-state for the instruction buffer and the registered head presented to decode.
    always_comb begin
        fifo_cnt_d  = fifo_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = 1'b0;
        out_addr_d  = out_addr_q;
        out_dat_d   = out_dat_q;
        credit_d    = 1'b0;

        if (redirect_valid) begin
            fifo_cnt_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
                2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
                default: fifo_cnt_d = fifo_cnt_q;
            endcase
            wr_ptr_d = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
            rd_ptr_d = pop_s ? rd_ptr_q + PW'(1) : rd_ptr_q;
        end

        out_valid_d = (fifo_cnt_d != '0);
        // A push into an otherwise empty buffer bypasses storage straight into the head.
        if (redirect_valid) begin
            out_valid_d = 1'b0;
        end else if (push_s && (remain_s == '0)) begin
            out_addr_d = tag_q[tag_rd_q];
            out_dat_d  = imem_rsp_data;
        end else if (fifo_cnt_d != '0) begin
            out_addr_d = fifo_addr_q[rd_ptr_d];
            out_dat_d  = fifo_dat_q[rd_ptr_d];
        end else begin
            out_addr_d = out_addr_q;
            out_dat_d  = out_dat_q;
        end

        credit_d = (32'(outstanding_d) < 32'(MAX_OUTSTANDING)) &&
                   ((32'(outstanding_d) + 32'(fifo_cnt_d)) < 32'(FIFO_DEPTH));
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            credit_q      <= 1'b0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            fifo_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            out_valid_q   <= 1'b0;
            out_addr_q    <= 32'h0000_0000;
            out_dat_q     <= 32'h0000_0000;
        end else begin
            pc_q          <= pc_d;
            credit_q      <= credit_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            fifo_cnt_q    <= fifo_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            out_valid_q   <= out_valid_d;
            out_addr_q    <= out_addr_d;
            out_dat_q     <= out_dat_d;
        end
    end

    // Buffer and tag storage; contents are qualified by the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_addr_q[wr_ptr_q] <= tag_q[tag_rd_q];
            fifo_dat_q[wr_ptr_q]  <= imem_rsp_data;
        end
        if (accept_s) begin
            tag_q[tag_wr_q] <= pc_q;
        end
    end

    fetch_unit_chk #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .OW              (OW)
    ) u_chk (
        .clk_i         (clk),
        .rst_i         (rst),
        .push_i        (push_s),
        .fifo_full_i   (fifo_full_s),
        .accept_i      (accept_s),
        .outstanding_i (outstanding_q)
    );

endmodule

// Protocol checks on internal occupancy; the credit rule should make both unreachable.
module fetch_unit_chk #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int OW              = 2
) (
    input logic          clk_i,
    input logic          rst_i,
    input logic          push_i,
    input logic          fifo_full_i,
    input logic          accept_i,
    input logic [OW-1:0] outstanding_i
);

    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && fifo_full_i));

    a_no_excess_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
        !(accept_i && (32'(outstanding_i) >= 32'(MAX_OUTSTANDING))));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order fixed-latency instruction memory model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        stall_in;
    logic        out_valid;
    logic [31:0] out_instr_addr;
    logic [31:0] out_instr_dat;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mreq_t;

    mreq_t       mq[$];
    int unsigned cyc;
    int unsigned lat;
    logic        spurious;
    int          pass_cnt;
    int          total_cnt;

    fetch_unit #(
        .RESET_PC        (32'h0000_0000),
        .FIFO_DEPTH      (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .stall_in       (stall_in),
        .out_valid      (out_valid),
        .out_instr_addr (out_instr_addr),
        .out_instr_dat  (out_instr_dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // One clock cycle: present any response due now, record an accepted request, then cross the edge.
    task automatic tick();
        int unsigned due;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0000_0000;
        if (spurious) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hBAD0_BAD0;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end
        #1;
        if (imem_req_valid === 1'b1 && imem_req_ready === 1'b1) begin
            due = cyc + lat;
            if (mq.size() > 0 && due <= mq[$].due) due = mq[$].due + 1;
            mq.push_back('{addr: imem_req_addr, due: due});
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        int k;
        rst = 1'b1;
        tick();
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid);
        else pass_cnt++;
        total_cnt++;
        if (out_instr_addr !== 32'h0) $display("FAIL reset_addr: got %h expected 00000000", out_instr_addr);
        else pass_cnt++;
        total_cnt++;
        if (out_instr_dat !== 32'h0) $display("FAIL reset_dat: got %h expected 00000000", out_instr_dat);
        else pass_cnt++;
        rst = 1'b0;
        total_cnt++;
        if (imem_req_valid !== 1'b0) $display("FAIL release_req_valid: got %b expected 0", imem_req_valid);
        else pass_cnt++;
        k = 0;
        while (out_valid !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        total_cnt++;
        if (k != 3) $display("FAIL first_valid_latency: got %0d cycles expected 3", k);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (out_valid !== 1'b1 || out_instr_addr !== 32'(4 * i) || out_instr_dat !== mem_word(32'(4 * i)))
                $display("FAIL stream_%0d: got v=%b addr=%h dat=%h expected v=1 addr=%h dat=%h",
                         i, out_valid, out_instr_addr, out_instr_dat, 32'(4 * i), mem_word(32'(4 * i)));
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_stall();
        stall_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            total_cnt++;
            if (out_valid !== 1'b1 || out_instr_addr !== 32'h10)
                $display("FAIL stall_hold_%0d: got v=%b addr=%h expected v=1 addr=00000010", i, out_valid, out_instr_addr);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (imem_req_valid !== 1'b0) $display("FAIL stall_full_req_valid: got %b expected 0", imem_req_valid);
        else pass_cnt++;
        spurious = 1'b1;
        tick();
        spurious = 1'b0;
        total_cnt++;
        if (out_instr_addr !== 32'h10 || imem_req_valid !== 1'b0)
            $display("FAIL spurious_rsp: got addr=%h req_valid=%b expected addr=00000010 req_valid=0", out_instr_addr, imem_req_valid);
        else pass_cnt++;
        stall_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (out_valid !== 1'b1 || out_instr_addr !== 32'(16 + 4 * i) || out_instr_dat !== mem_word(32'(16 + 4 * i)))
                $display("FAIL stall_release_%0d: got v=%b addr=%h dat=%h expected v=1 addr=%h",
                         i, out_valid, out_instr_addr, out_instr_dat, 32'(16 + 4 * i));
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_redirect_drop();
        int k;
        lat = 3;
        k = 0;
        while (mq.size() != 2 && k < 20) begin
            tick();
            k++;
        end
        total_cnt++;
        if (mq.size() != 2) $display("FAIL redir_setup: got %0d outstanding expected 2", mq.size());
        else pass_cnt++;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0203;
        #1;
        total_cnt++;
        if (imem_req_valid !== 1'b0) $display("FAIL redir_withdraw: got %b expected 0", imem_req_valid);
        else pass_cnt++;
        tick();
        redirect_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL redir_flush: got %b expected 0", out_valid);
        else pass_cnt++;
        for (int n = 0; n < 2; n++) begin
            k = 0;
            while (out_valid !== 1'b1 && k < 30) begin
                tick();
                k++;
            end
            total_cnt++;
            if (out_valid !== 1'b1 || out_instr_addr !== 32'(32'h200 + 4 * n) || out_instr_dat !== mem_word(32'(32'h200 + 4 * n)))
                $display("FAIL redir_target_%0d: got v=%b addr=%h dat=%h expected v=1 addr=%h",
                         n, out_valid, out_instr_addr, out_instr_dat, 32'(32'h200 + 4 * n));
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_redirect_rsp_stall();
        int k;
        lat = 1;
        for (int i = 0; i < 8; i++) tick();
        stall_in = 1'b1;
        tick();
        k = 0;
        while (!(mq.size() > 0 && mq[0].due <= cyc) && k < 10) begin
            tick();
            k++;
        end
        total_cnt++;
        if (!(mq.size() > 0 && mq[0].due <= cyc) || out_valid !== 1'b1)
            $display("FAIL rsp_stall_setup: got rsp_due=%0d v=%b expected rsp_due=1 v=1", mq.size(), out_valid);
        else pass_cnt++;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0301;
        tick();
        redirect_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL rsp_stall_flush: got %b expected 0", out_valid);
        else pass_cnt++;
        k = 0;
        while (out_valid !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        total_cnt++;
        if (out_valid !== 1'b1 || out_instr_addr !== 32'h300 || out_instr_dat !== mem_word(32'h300))
            $display("FAIL rsp_stall_target: got v=%b addr=%h dat=%h expected v=1 addr=00000300 dat=%h",
                     out_valid, out_instr_addr, out_instr_dat, mem_word(32'h300));
        else pass_cnt++;
        stall_in = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        int          k;
        logic [31:0] exp_addr;
        redirect_valid = 1'b1;
        redirect_addr  = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        exp_addr = 32'hFFFF_FFF8;
        for (int n = 0; n < 3; n++) begin
            k = 0;
            while (out_valid !== 1'b1 && k < 20) begin
                tick();
                k++;
            end
            total_cnt++;
            if (out_valid !== 1'b1 || out_instr_addr !== exp_addr || out_instr_dat !== mem_word(exp_addr))
                $display("FAIL wrap_%0d: got v=%b addr=%h dat=%h expected v=1 addr=%h",
                         n, out_valid, out_instr_addr, out_instr_dat, exp_addr);
            else pass_cnt++;
            exp_addr = exp_addr + 32'd4;
            tick();
        end
    endtask

    task automatic test_async_reset();
        int k;
        tick();
        tick();
        stall_in = 1'b1;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || imem_req_valid !== 1'b0 || out_instr_addr !== 32'h0)
            $display("FAIL async_reset: got v=%b req_valid=%b addr=%h expected 0 0 00000000",
                     out_valid, imem_req_valid, out_instr_addr);
        else pass_cnt++;
        mq.delete();
        stall_in = 1'b0;
        tick();
        rst = 1'b0;
        k = 0;
        while (out_valid !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        total_cnt++;
        if (k != 3 || out_instr_addr !== 32'h0 || out_instr_dat !== mem_word(32'h0))
            $display("FAIL restart_first: got cycles=%0d addr=%h expected cycles=3 addr=00000000", k, out_instr_addr);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b1 || out_instr_addr !== 32'h4)
            $display("FAIL restart_second: got v=%b addr=%h expected v=1 addr=00000004", out_valid, out_instr_addr);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt       = 0;
        total_cnt      = 0;
        cyc            = 0;
        lat            = 1;
        spurious       = 1'b0;
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0000_0000;
        redirect_valid = 1'b0;
        redirect_addr  = 32'h0000_0000;
        stall_in       = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drop();
        test_redirect_rsp_stall();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
